// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and the
// signed-overflow rule used when the final chunk is written.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operands of equal sign producing a sum of the opposite sign.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice: a ripple adder of full adders plus the
// bitwise ops. b_k_i is already inverted for SUB/SLT by the caller.
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_k_i,
    input  logic [CHUNK-1:0] b_k_i,
    input  logic             cin_i,
    input  logic [2:0]       op_i,
    output logic [CHUNK-1:0] out_k_o,
    output logic             cout_o,
    output logic             sum_msb_o
);

    logic [CHUNK:0]   carry;
    logic [CHUNK-1:0] sum;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fulladder u_fa (
            .a_i    (a_k_i[i]),
            .b_i    (b_k_i[i]),
            .cin_i  (carry[i]),
            .sum_o  (sum[i]),
            .cout_o (carry[i+1])
        );
    end

    assign cout_o    = carry[CHUNK];
    assign sum_msb_o = sum[CHUNK-1];

    // NOTE: every output of a combinational block needs a value on every path,
    // otherwise synthesis infers a latch; the default arm guarantees that here.
    always_comb begin
        unique case (op_i)
            OP_ADD, OP_SUB, OP_SLT: out_k_o = sum;
            OP_XOR:                 out_k_o = a_k_i ^ b_k_i;
            OP_AND:                 out_k_o = a_k_i & b_k_i;
            OP_NAND:                out_k_o = ~(a_k_i & b_k_i);
            OP_NOR:                 out_k_o = ~(a_k_i | b_k_i);
            default:                out_k_o = a_k_i | b_k_i;
        endcase
    end

endmodule

// File: rtl/fulladder.sv
// One-bit full adder, the building block of the chunk add path.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: processes CHUNK bits per clock from the LSB upwards with a
// registered carry, behind valid/ready handshakes on both sides.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic             carry_q, carryout_q, overflow_q, zero_q;

    logic             sub_in, accept;
    int unsigned      base;
    logic [CHUNK-1:0] a_k, b_k, out_k;
    logic             cout_k, sum_msb;
    logic [WIDTH-1:0] result_d, final_d;
    logic             ovf_d, carryout_d, overflow_d, zero_d;

    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign sub_in    = (op == OP_SUB) || (op == OP_SLT);

    assign result   = result_q;
    assign carryout = carryout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

    always_comb begin
        base = int'(cnt_q) * CHUNK;
        a_k  = CHUNK'(a_q >> base);
        b_k  = CHUNK'(b_q >> base);
    end

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_k_i     (a_k),
        .b_k_i     (b_k),
        .cin_i     (carry_q),
        .op_i      (op_q),
        .out_k_o   (out_k),
        .cout_o    (cout_k),
        .sum_msb_o (sum_msb)
    );

    // Merge chunk k into the result; flags only matter on the last chunk.
    always_comb begin
        result_d   = (result_q & ~(CHUNK_MASK << base)) | (WIDTH'(out_k) << base);
        ovf_d      = signed_overflow(a_q[WIDTH-1], b_q[WIDTH-1], sum_msb);
        final_d    = result_d;
        carryout_d = 1'b0;
        overflow_d = 1'b0;
        unique case (op_q)
            OP_ADD, OP_SUB: begin
                carryout_d = cout_k;
                overflow_d = ovf_d;
            end
            OP_SLT:  final_d = WIDTH'(sum_msb ^ ovf_d);
            default: ;
        endcase
        zero_d = (final_d == '0);
    end

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        carry_q <= sub_in;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    carry_q <= cout_k;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CHUNK) begin
                        result_q   <= final_d;
                        carryout_q <= carryout_d;
                        overflow_q <= overflow_d;
                        zero_q     <= zero_d;
                        state_q    <= S_DONE;
                    end else begin
                        result_q <= result_d;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand registers are pure datapath, loaded on acceptance and
    // never read outside BUSY, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= b ^ {WIDTH{sub_in}};
            op_q <= op;
        end
    end

endmodule
